// File: rtl/apb3_slot_sequencer_if.sv
// Request/response and APB3 slot-bus signals of the slot sequencer.
// The master modport is the sequencer's view; the slave modport is the requester and slot fabric view.
interface apb3_slot_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_write;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [16:0]       PSELS;
    logic [ADDR_W-1:0] PADDR;
    logic              PWRITE;
    logic              PENABLE;
    logic [31:0]       PWDATA;
    logic              PREADY;
    logic              PSLVERR;
    logic [31:0]       PRDATA;

    modport master (
        input  req_valid, req_addr, req_write, req_wdata, PREADY, PSLVERR, PRDATA,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, PSELS, PADDR, PWRITE, PENABLE, PWDATA
    );

    modport slave (
        output req_valid, req_addr, req_write, req_wdata, PREADY, PSLVERR, PRDATA,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, PSELS, PADDR, PWRITE, PENABLE, PWDATA
    );
endinterface

// File: rtl/apb3_slot_sequencer.sv
// Single-master APB3 sequencer driving a 17-slot bus; one request in flight, one-cycle response strobe.
// Define APB3_SEQ_TIMEOUT_EN to abort ACCESS phases that wait TIMEOUT_CYC cycles without PREADY.
module apb3_slot_sequencer #(
    parameter int ADDR_W      = 32,
    parameter int SLOT_LSB    = 24,
    parameter int TIMEOUT_CYC = 256
) (
    input logic                  PCLK,
    input logic                  PRESETN,
    apb3_slot_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    if (SLOT_LSB + 4 >= ADDR_W || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_param_check
        $error("apb3_slot_sequencer: illegal SLOT_LSB/ADDR_W/TIMEOUT_CYC combination");
    end

    state_t            state_q;
    logic [ADDR_W-1:0] paddr_q;
    logic              pwrite_q;
    logic [31:0]       pwdata_q;
    logic [16:0]       psels_q;
    logic              penable_q;
    logic              rsp_valid_q;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_err_q;
`ifdef APB3_SEQ_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0]       cnt_q;
`endif

    logic [4:0]  slot_d;
    logic [16:0] psels_d;

    // Slots 17..31 decode to an all-zero select and are reported as decode errors.
    always_comb begin
        slot_d  = bus.req_addr[SLOT_LSB +: 5];
        psels_d = '0;
        for (int i = 0; i < 17; i++) begin
            psels_d[i] = (slot_d == 5'(i));
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            state_q     <= IDLE;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            psels_q     <= '0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef APB3_SEQ_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        paddr_q  <= bus.req_addr;
                        pwrite_q <= bus.req_write;
                        pwdata_q <= bus.req_wdata;
                        if (slot_d <= 5'd16) begin
                            psels_q <= psels_d;
                            state_q <= SETUP;
                        end else begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                            state_q     <= RESP;
                        end
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
`ifdef APB3_SEQ_TIMEOUT_EN
                    cnt_q     <= '0;
`endif
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    // A ready slave wins over a timeout expiring in the same cycle.
                    if (bus.PREADY) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= bus.PSLVERR;
                        rsp_rdata_q <= pwrite_q ? 32'd0 : bus.PRDATA;
                        psels_q     <= '0;
                        penable_q   <= 1'b0;
                        state_q     <= RESP;
                    end
`ifdef APB3_SEQ_TIMEOUT_EN
                    else if (cnt_q == TO_LAST) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                        psels_q     <= '0;
                        penable_q   <= 1'b0;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
`endif
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.PSELS     = psels_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWDATA    = pwdata_q;
endmodule

// File: tb/tb_apb3_slot_sequencer.sv
// Self-checking bench for apb3_slot_sequencer: directed transfers, a mid-transfer reset,
// the timeout behaviour for the current build, and randomized transfers against a cycle-indexed model.
module tb_apb3_slot_sequencer;
    localparam int ADDR_W      = 32;
    localparam int SLOT_LSB    = 24;
    localparam int TIMEOUT_CYC = 4;

    logic PCLK = 1'b0;
    logic PRESETN;
    int   errors = 0;
    int   checks = 0;

    apb3_slot_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    apb3_slot_sequencer #(
        .ADDR_W(ADDR_W),
        .SLOT_LSB(SLOT_LSB),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .PCLK(PCLK),
        .PRESETN(PRESETN),
        .bus(bus)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected behaviour per cycle after the accept edge, derived from the transfer's timing rules:
    // SETUP in cycle 1, ACCESS in cycles 2..2+waits, response in the cycle after, IDLE after that.
    task automatic runTransfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                               input int waits, input logic [31:0] rd, input logic slverr,
                               input logic neverReady);
        logic [4:0]  slot;
        logic        decErr;
        logic [16:0] expSel;
        int          rspCyc;
        logic        expErr;
        logic [31:0] expData;
        logic        inAccess;
        logic        inSelect;
        slot    = addr[SLOT_LSB +: 5];
        decErr  = (slot > 5'd16);
        expSel  = decErr ? 17'd0 : (17'(1) << slot);
        rspCyc  = decErr ? 1 : 3 + waits;
        expErr  = decErr | neverReady | slverr;
        expData = (decErr || neverReady || wr) ? 32'd0 : rd;

        @(negedge PCLK);
        check("acceptReady", 64'(bus.req_ready), 64'(1));
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_write = wr;
        bus.req_wdata = wd;
        @(posedge PCLK);
        #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom();
        bus.req_wdata = $urandom();
        bus.req_write = 1'($urandom());

        for (int c = 1; c <= rspCyc + 1; c++) begin
            @(negedge PCLK);
            inSelect = !decErr && (c <= 2 + waits);
            inAccess = inSelect && (c >= 2);
            check("PSELS",     64'(bus.PSELS),     inSelect ? 64'(expSel) : 64'(0));
            check("PENABLE",   64'(bus.PENABLE),   64'(inAccess));
            check("rspValid",  64'(bus.rsp_valid), 64'(c == rspCyc));
            check("reqReady",  64'(bus.req_ready), 64'(c == rspCyc + 1));
            check("PADDR",     64'(bus.PADDR),     64'(addr));
            check("PWRITE",    64'(bus.PWRITE),    64'(wr));
            check("PWDATA",    64'(bus.PWDATA),    64'(wd));
            if (c >= rspCyc) begin
                check("rspRdata", 64'(bus.rsp_rdata), 64'(expData));
                check("rspErr",   64'(bus.rsp_err),   64'(expErr));
            end
            bus.PREADY  = inAccess && !neverReady && (c == 2 + waits);
            bus.PRDATA  = bus.PREADY ? rd : $urandom();
            bus.PSLVERR = bus.PREADY ? slverr : 1'($urandom());
        end
        bus.PREADY = 1'b0;
    endtask

    initial begin
        logic        sawRsp;
        logic [4:0]  rSlot;
        logic [31:0] rAddr;
        int          cyc;

        PRESETN       = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_write = 1'b0;
        bus.req_wdata = '0;
        bus.PREADY    = 1'b0;
        bus.PSLVERR   = 1'b0;
        bus.PRDATA    = '0;
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        check("rstReqReady", 64'(bus.req_ready), 64'(1));
        check("rstRspValid", 64'(bus.rsp_valid), 64'(0));
        check("rstRdata",    64'(bus.rsp_rdata), 64'(0));
        check("rstErr",      64'(bus.rsp_err),   64'(0));
        check("rstPsels",    64'(bus.PSELS),     64'(0));
        check("rstPaddr",    64'(bus.PADDR),     64'(0));
        check("rstPwrite",   64'(bus.PWRITE),    64'(0));
        check("rstPenable",  64'(bus.PENABLE),   64'(0));
        check("rstPwdata",   64'(bus.PWDATA),    64'(0));
        PRESETN = 1'b1;

        $display("[TB] directed transfers");
        runTransfer(32'h0300_0010, 1'b0, 32'h0000_0000, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        runTransfer(32'h1000_0000, 1'b1, 32'h1234_5678, 3, 32'h5555_AAAA, 1'b0, 1'b0);
        runTransfer(32'h0000_0040, 1'b0, 32'h0000_0000, 1, 32'hCAFE_F00D, 1'b1, 1'b0);
        runTransfer(32'h1F00_0000, 1'b0, 32'h0000_0000, 0, 32'h0000_0000, 1'b0, 1'b0);
        runTransfer(32'h1100_0004, 1'b1, 32'hFFFF_0000, 0, 32'h0000_0000, 1'b0, 1'b0);

`ifdef APB3_SEQ_TIMEOUT_EN
        $display("[TB] timeout with PREADY held low");
        runTransfer(32'h0500_0000, 1'b0, 32'h0000_0000, TIMEOUT_CYC - 1, 32'h0000_0000, 1'b0, 1'b1);
`else
        $display("[TB] no timeout: PREADY held low for 1000 cycles");
        @(negedge PCLK);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0500_0008;
        bus.req_write = 1'b0;
        @(posedge PCLK);
        #1;
        bus.req_valid = 1'b0;
        sawRsp = 1'b0;
        repeat (1000) begin
            @(negedge PCLK);
            if (bus.rsp_valid) sawRsp = 1'b1;
        end
        check("noTimeoutRsp", 64'(sawRsp),      64'(0));
        check("stillAccess",  64'(bus.PENABLE), 64'(1));
        check("stillSelect",  64'(bus.PSELS),   64'(17'h00020));
        bus.PREADY  = 1'b1;
        bus.PRDATA  = 32'hA5A5_5A5A;
        bus.PSLVERR = 1'b0;
        @(negedge PCLK);
        bus.PREADY = 1'b0;
        check("lateRspValid", 64'(bus.rsp_valid), 64'(1));
        check("lateRdata",    64'(bus.rsp_rdata), 64'(32'hA5A5_5A5A));
        check("lateErr",      64'(bus.rsp_err),   64'(0));
        @(negedge PCLK);
        check("lateIdle",     64'(bus.req_ready), 64'(1));
`endif

        $display("[TB] reset during ACCESS");
        @(negedge PCLK);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0200_0000;
        bus.req_write = 1'b1;
        bus.req_wdata = 32'h0BAD_0BAD;
        @(posedge PCLK);
        #1;
        bus.req_valid = 1'b0;
        bus.PREADY    = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        check("preRstAccess", 64'(bus.PENABLE), 64'(1));
        PRESETN = 1'b0;
        @(negedge PCLK);
        PRESETN = 1'b1;
        check("rstMidPsels",   64'(bus.PSELS),     64'(0));
        check("rstMidPenable", 64'(bus.PENABLE),   64'(0));
        check("rstMidReady",   64'(bus.req_ready), 64'(1));
        check("rstMidRsp",     64'(bus.rsp_valid), 64'(0));
        check("rstMidPaddr",   64'(bus.PADDR),     64'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            check("rstNoRsp", 64'(bus.rsp_valid), 64'(0));
        end
        runTransfer(32'h0700_0100, 1'b0, 32'h0000_0000, 2, 32'h1357_9BDF, 1'b0, 1'b0);

        $display("[TB] randomized transfers");
        for (int n = 0; n < 24; n++) begin
            rSlot = 5'($urandom_range(0, 31));
            rAddr = $urandom();
            rAddr[SLOT_LSB +: 5] = rSlot;
            cyc = $urandom_range(0, 3);
            runTransfer(rAddr, 1'($urandom()), $urandom(), cyc, $urandom(), 1'($urandom()), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
